// File: rtl/bp_gshare_table_pkg.sv
// Shared definitions for the gshare predictor: default geometry and the
// 2-bit counter encoding.
package bp_gshare_table_pkg;

  localparam int BP_IDX_W  = 6;
  localparam int BP_GHR_W  = 6;
  localparam int BP_PC_W   = 16;
  localparam int BP_STAT_W = 16;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_RESET = BP_WNT;

endpackage

// File: rtl/bp_gshare_table_ctr2_next.sv
// Next-state function of a 2-bit saturating branch counter; shared by the
// table write path and the lookup bypass.
module bp_ctr2_next
  import bp_gshare_table_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       actual_i,
  output logic [1:0] ctr_next_o
);

  always_comb begin
    ctr_next_o = ctr_i;
    case (ctr_i)
      BP_SNT:  ctr_next_o = actual_i ? BP_WNT : BP_SNT;
      BP_WNT:  ctr_next_o = actual_i ? BP_WT  : BP_SNT;
      BP_WT:   ctr_next_o = actual_i ? BP_ST  : BP_WNT;
      BP_ST:   ctr_next_o = actual_i ? BP_ST  : BP_WT;
      default: ctr_next_o = BP_CTR_RESET;
    endcase
  end

endmodule

// File: rtl/bp_gshare_table.sv
// Gshare pattern history table: lookup indexed by PC ^ GHR with a one-cycle
// registered prediction, trained by resolved branches from execute.
module bp_gshare_table
  import bp_gshare_table_pkg::*;
#(
  parameter int IDX_W  = BP_IDX_W,
  parameter int GHR_W  = BP_GHR_W,
  parameter int PC_W   = BP_PC_W,
  parameter int STAT_W = BP_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid_i,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              update_valid_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_actual_i,
  input  logic              update_pred_i,
  output logic [GHR_W-1:0]  ghr_out_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        table_q [DEPTH];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;

  logic [IDX_W-1:0]  lkp_idx_s;
  logic [1:0]        upd_ctr_next_s;

  assign lkp_idx_s = lookup_pc_i[IDX_W-1:0] ^ ghr_q;

  bp_ctr2_next u_ctr_next (
    .ctr_i      (table_q[update_idx_i]),
    .actual_i   (update_actual_i),
    .ctr_next_o (upd_ctr_next_s)
  );

  // Next-state for GHR, statistics and the prediction registers.
  always_comb begin
    ghr_d        = ghr_q;
    branches_d   = branches_q;
    mispred_d    = mispred_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (update_valid_i) begin
      ghr_d = {ghr_q[GHR_W-2:0], update_actual_i};
      if (branches_q != {STAT_W{1'b1}}) begin
        branches_d = branches_q + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        branches_d = branches_q;
      end
      if ((update_pred_i != update_actual_i) && (mispred_q != {STAT_W{1'b1}})) begin
        mispred_d = mispred_q + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        mispred_d = mispred_q;
      end
    end else begin
      ghr_d = ghr_q;
    end
    if (lookup_valid_i) begin
      pred_valid_d = 1'b1;
      pred_idx_d   = lkp_idx_s;
      // A same-cycle update to this entry is forwarded so fetch sees the trained value.
      if (update_valid_i && (update_idx_i == lkp_idx_s)) begin
        pred_taken_d = upd_ctr_next_s[1];
      end else begin
        pred_taken_d = table_q[lkp_idx_s][1];
      end
    end else begin
      pred_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= BP_CTR_RESET;
      end
      ghr_q        <= {GHR_W{1'b0}};
      branches_q   <= {STAT_W{1'b0}};
      mispred_q    <= {STAT_W{1'b0}};
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= {IDX_W{1'b0}};
    end else begin
      if (update_valid_i) begin
        table_q[update_idx_i] <= upd_ctr_next_s;
      end
      ghr_q        <= ghr_d;
      branches_q   <= branches_d;
      mispred_q    <= mispred_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid_o    = pred_valid_q;
  assign pred_taken_o    = pred_taken_q;
  assign pred_idx_o      = pred_idx_q;
  assign ghr_out_o       = ghr_q;
  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_bp_gshare_table.sv
// Directed self-checking bench for bp_gshare_table.
module tb_bp_gshare_table;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [15:0] lookup_pc = 16'h0000;
  logic        pred_valid, pred_taken;
  logic [5:0]  pred_idx;
  logic        update_valid = 1'b0;
  logic [5:0]  update_idx = 6'd0;
  logic        update_actual = 1'b0;
  logic        update_pred = 1'b0;
  logic [5:0]  ghr_out;
  logic [15:0] stat_branches, stat_mispred;

  int n_tests = 0;
  int n_fail  = 0;

  bp_gshare_table dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid_i  (lookup_valid),
    .lookup_pc_i     (lookup_pc),
    .pred_valid_o    (pred_valid),
    .pred_taken_o    (pred_taken),
    .pred_idx_o      (pred_idx),
    .update_valid_i  (update_valid),
    .update_idx_i    (update_idx),
    .update_actual_i (update_actual),
    .update_pred_i   (update_pred),
    .ghr_out_o       (ghr_out),
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic upd(input logic [5:0] idx, input logic act, input logic prd);
    update_valid  = 1'b1;
    update_idx    = idx;
    update_actual = act;
    update_pred   = prd;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  // Saturation vectors on idx 5: {lookup pc giving idx 5 under current GHR, expected taken}
  logic [15:0] sat_pc    [4] = '{16'h0003, 16'h0009, 16'h001D, 16'h0035};
  logic        sat_taken [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    check_eq("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("rst_pred_idx", {26'd0, pred_idx}, 32'd0);
    check_eq("rst_ghr", {26'd0, ghr_out}, 32'd0);
    check_eq("rst_branches", {16'd0, stat_branches}, 32'd0);
    check_eq("rst_mispred", {16'd0, stat_mispred}, 32'd0);

    // First lookup: weak-NT entry, idx = pc
    look(16'h0005);
    check_eq("lk0_valid", {31'd0, pred_valid}, 32'd1);
    check_eq("lk0_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("lk0_idx", {26'd0, pred_idx}, 32'd5);
    check_eq("lk0_ghr", {26'd0, ghr_out}, 32'd0);
    tick();
    check_eq("idle_valid", {31'd0, pred_valid}, 32'd0);
    check_eq("idle_idx_hold", {26'd0, pred_idx}, 32'd5);

    // Train idx 5 twice taken: 01 -> 10 -> 11; GHR becomes 000011
    upd(6'd5, 1'b1, 1'b0);
    upd(6'd5, 1'b1, 1'b1);
    check_eq("train_ghr", {26'd0, ghr_out}, 32'h03);
    look(16'h0006);
    check_eq("train_idx", {26'd0, pred_idx}, 32'd5);
    check_eq("train_taken", {31'd0, pred_taken}, 32'd1);

    // Four not-taken updates: 11 -> 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      upd(6'd5, 1'b0, 1'b1);
      look(sat_pc[i]);
      check_eq($sformatf("sat%0d_idx", i), {26'd0, pred_idx}, 32'd5);
      check_eq($sformatf("sat%0d_taken", i), {31'd0, pred_taken}, {31'd0, sat_taken[i]});
    end
    // One taken update from 00 lands on 01, still not-taken
    upd(6'd5, 1'b1, 1'b0);
    check_eq("sat_ghr", {26'd0, ghr_out}, 32'h21);
    look(16'h0024);
    check_eq("sat_up_idx", {26'd0, pred_idx}, 32'd5);
    check_eq("sat_up_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("sat_branches", {16'd0, stat_branches}, 32'd7);
    check_eq("sat_mispred", {16'd0, stat_mispred}, 32'd6);

    // Bypass: same-cycle lookup and update on idx 3
    do_reset();
    lookup_valid = 1'b1;
    lookup_pc    = 16'h0003;
    upd(6'd3, 1'b1, 1'b1);
    lookup_valid = 1'b0;
    check_eq("byp_valid", {31'd0, pred_valid}, 32'd1);
    check_eq("byp_idx", {26'd0, pred_idx}, 32'd3);
    check_eq("byp_taken", {31'd0, pred_taken}, 32'd1);
    check_eq("byp_ghr", {26'd0, ghr_out}, 32'd1);

    // GHR shifting and upper PC bits ignored in index
    do_reset();
    upd(6'd10, 1'b1, 1'b1);
    upd(6'd11, 1'b0, 1'b0);
    upd(6'd12, 1'b1, 1'b1);
    check_eq("ghr_101", {26'd0, ghr_out}, 32'h05);
    look(16'h0007);
    check_eq("ghr_idx", {26'd0, pred_idx}, 32'h02);
    check_eq("ghr_taken", {31'd0, pred_taken}, 32'd0);
    look(16'hFFC7);
    check_eq("wrap_idx", {26'd0, pred_idx}, 32'h02);

    // Statistics then mid-operation reset
    do_reset();
    for (int i = 0; i < 3; i++) upd(6'd0, 1'b1, 1'b0);
    check_eq("st_branches", {16'd0, stat_branches}, 32'd3);
    check_eq("st_mispred", {16'd0, stat_mispred}, 32'd3);
    look(16'h0003);
    check_eq("st_pre_valid", {31'd0, pred_valid}, 32'd1);
    lookup_valid  = 1'b1;
    lookup_pc     = 16'h0003;
    update_valid  = 1'b1;
    update_idx    = 6'd0;
    update_actual = 1'b1;
    update_pred   = 1'b0;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    lookup_valid  = 1'b0;
    update_valid  = 1'b0;
    check_eq("mid_valid", {31'd0, pred_valid}, 32'd0);
    check_eq("mid_branches", {16'd0, stat_branches}, 32'd0);
    check_eq("mid_mispred", {16'd0, stat_mispred}, 32'd0);
    check_eq("mid_ghr", {26'd0, ghr_out}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      look(i[15:0]);
      check_eq($sformatf("mid_e%0d_idx", i), {26'd0, pred_idx}, i);
      check_eq($sformatf("mid_e%0d_taken", i), {31'd0, pred_taken}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
